// File: rtl/pir_event_logger_pkg.sv
// pir_pkg: shared definitions for the PIR event logger.
//   - FSM state encoding (OFF / RUN / FLUSH)
//   - 16-bit event record: [15:14] channel id, [13:7] level, [6:0] timestamp
//   - sensor level width and default motion threshold
package pir_pkg;

    localparam int unsigned PIR_LEVEL_W    = 7;
    localparam int unsigned PIR_CHAN_W     = 2;
    localparam int unsigned PIR_TS_W       = 7;
    localparam int unsigned PIR_REC_W      = PIR_CHAN_W + PIR_LEVEL_W + PIR_TS_W;
    localparam int unsigned PIR_THRESH_DEF = 50;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } pir_state_e;

    typedef struct packed {
        logic [PIR_CHAN_W-1:0]  chan;
        logic [PIR_LEVEL_W-1:0] level;
        logic [PIR_TS_W-1:0]    ts;
    } pir_rec_t;

endpackage

// File: rtl/pir_event_logger_arb.sv
// pir_rr_arbiter: round-robin arbiter for the PIR channels.
// Ports:
//   clk, rst  - clock, async active-high reset
//   req_i     - one request bit per channel
//   gnt_o     - one-hot grant (all zero when no request)
// The last-grant register is one-hot; all-zero (reset value) means "no grant
// yet", which makes channel 0 the first candidate.
module pir_rr_arbiter #(
    parameter int unsigned NUM_SENS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_SENS-1:0] req_i,
    output logic [NUM_SENS-1:0] gnt_o
);

    localparam int unsigned IW = $clog2(NUM_SENS);

    logic [NUM_SENS-1:0] last_q;
    logic [IW-1:0]       start_w;
    logic [IW:0]         sum_w;
    logic                found_w;

    always_comb begin
        // Search begins one past the previously granted channel.
        start_w = '0;
        for (int unsigned i = 0; i < NUM_SENS; i++) begin
            if (last_q[i]) start_w = (i == NUM_SENS - 1) ? '0 : IW'(i + 1);
        end
        gnt_o   = '0;
        found_w = 1'b0;
        sum_w   = '0;
        for (int unsigned k = 0; k < NUM_SENS; k++) begin
            sum_w = {1'b0, start_w} + (IW+1)'(k);
            if (sum_w >= (IW+1)'(NUM_SENS)) sum_w = sum_w - (IW+1)'(NUM_SENS);
            if (!found_w && req_i[sum_w[IW-1:0]]) begin
                gnt_o[sum_w[IW-1:0]] = 1'b1;
                found_w              = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         last_q <= '0;
        else if (|gnt_o) last_q <= gnt_o;
    end

endmodule

// File: rtl/pir_event_logger.sv
// pir_event_logger: captures PIR threshold crossings into an event FIFO.
// Ports:
//   clk, rst   - clock, async active-high reset
//   turn       - 1 = armed, 0 = off
//   clear      - one-cycle pulse flushing buffer and overflow count
//   pir_level  - NUM_SENS packed 7-bit levels, channel 0 in [6:0]
//   rd_req     - pop oldest event
//   rd_valid   - one-cycle strobe, rd_data valid
//   rd_data    - {chan[1:0], level[6:0], ts[6:0]}
//   count      - stored events (0..DEPTH)
//   overflow   - dropped events, saturating at 255
//   busy       - any channel pending or in holdoff
// Build option: define PIR_LOG_TIMESTAMP_EN to add a 7-bit free-running
// timestamp (runs in RUN); otherwise the timestamp field reads 0.
module pir_event_logger
    import pir_pkg::*;
#(
    parameter int unsigned NUM_SENS = 3,
    parameter int unsigned THRESH   = PIR_THRESH_DEF,
    parameter int unsigned HOLDOFF  = 100,
    parameter int unsigned DEPTH    = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            turn,
    input  logic                            clear,
    input  logic [NUM_SENS*PIR_LEVEL_W-1:0] pir_level,
    input  logic                            rd_req,
    output logic                            rd_valid,
    output logic [PIR_REC_W-1:0]            rd_data,
    output logic [3:0]                      count,
    output logic [7:0]                      overflow,
    output logic                            busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned HW = $clog2(HOLDOFF + 1);
    localparam logic [PIR_LEVEL_W-1:0] THR = PIR_LEVEL_W'(THRESH);

    pir_state_e state_q;
    logic       run_w, flush_w;

    // Flush actions take effect on the clear edge itself, so results are
    // visible the very next cycle; the FLUSH state repeats them once more.
    assign flush_w = clear || (state_q == ST_FLUSH);
    assign run_w   = (state_q == ST_RUN) && !clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_OFF;
        end else if (clear) begin
            state_q <= ST_FLUSH;
        end else begin
            case (state_q)
                ST_OFF:   if (turn) state_q <= ST_RUN;
                ST_RUN:   if (!turn) state_q <= ST_OFF;
                ST_FLUSH: state_q <= turn ? ST_RUN : ST_OFF;
                default:  state_q <= ST_OFF;
            endcase
        end
    end

    logic [PIR_TS_W-1:0] ts_w;
`ifdef PIR_LOG_TIMESTAMP_EN
    logic [PIR_TS_W-1:0] ts_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     ts_q <= '0;
        else if (state_q == ST_RUN)  ts_q <= ts_q + 1'b1;
    end
    assign ts_w = ts_q;
`else
    assign ts_w = '0;
`endif

    // Per-channel trigger, pending capture and holdoff
    logic [NUM_SENS-1:0]    above_w, trig_w, gnt_w, pend_q, hist_q;
    logic [PIR_LEVEL_W-1:0] lvl_q  [NUM_SENS];
    logic [PIR_TS_W-1:0]    tsc_q  [NUM_SENS];
    logic [HW-1:0]          hold_q [NUM_SENS];

    always_comb begin
        for (int unsigned i = 0; i < NUM_SENS; i++) begin
            above_w[i] = pir_level[i*PIR_LEVEL_W +: PIR_LEVEL_W] >= THR;
            trig_w[i]  = run_w && above_w[i] && !hist_q[i] && !pend_q[i] &&
                         (hold_q[i] == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            hist_q <= '0;
            for (int unsigned i = 0; i < NUM_SENS; i++) begin
                lvl_q[i]  <= '0;
                tsc_q[i]  <= '0;
                hold_q[i] <= '0;
            end
        end else begin
            hist_q <= above_w;
            for (int unsigned i = 0; i < NUM_SENS; i++) begin
                if (!run_w) begin
                    pend_q[i] <= 1'b0;
                    hold_q[i] <= '0;
                end else if (gnt_w[i]) begin
                    pend_q[i] <= 1'b0;
                    hold_q[i] <= HW'(HOLDOFF);
                end else begin
                    if (trig_w[i]) begin
                        pend_q[i] <= 1'b1;
                        lvl_q[i]  <= pir_level[i*PIR_LEVEL_W +: PIR_LEVEL_W];
                        tsc_q[i]  <= ts_w;
                    end
                    if (hold_q[i] != '0) hold_q[i] <= hold_q[i] - 1'b1;
                end
            end
        end
    end

    pir_rr_arbiter #(
        .NUM_SENS(NUM_SENS)
    ) u_arb (
        .clk  (clk),
        .rst  (rst),
        .req_i(pend_q & {NUM_SENS{run_w}}),
        .gnt_o(gnt_w)
    );

    pir_rec_t wr_rec_w;
    always_comb begin
        wr_rec_w = '0;
        for (int unsigned i = 0; i < NUM_SENS; i++) begin
            if (gnt_w[i]) begin
                wr_rec_w.chan  = PIR_CHAN_W'(i);
                wr_rec_w.level = lvl_q[i];
                wr_rec_w.ts    = tsc_q[i];
            end
        end
    end

    // Event buffer
    pir_rec_t      mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [3:0]    count_q;
    logic [7:0]    ovf_q;
    logic          rd_valid_q;
    pir_rec_t      rd_data_q;
    logic          wr_w, pop_w, full_w, acc_w;

    assign wr_w   = |gnt_w;
    assign pop_w  = rd_req && (count_q != '0) && !flush_w;
    assign full_w = (count_q == 4'(DEPTH));
    // A same-cycle pop frees the slot, so a write into a full buffer is kept.
    assign acc_w  = wr_w && (!full_w || pop_w);

    always_ff @(posedge clk) begin
        if (acc_w) mem_q[wr_ptr_q] <= wr_rec_w;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else if (flush_w) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            if (acc_w) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_w) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                rd_data_q <= mem_q[rd_ptr_q];
            end
            rd_valid_q <= pop_w;
            count_q    <= count_q + {3'b0, acc_w} - {3'b0, pop_w};
            if (wr_w && !acc_w && (ovf_q != 8'hFF)) ovf_q <= ovf_q + 1'b1;
        end
    end

    logic busy_w;
    always_comb begin
        busy_w = |pend_q;
        for (int unsigned i = 0; i < NUM_SENS; i++) begin
            if (hold_q[i] != '0) busy_w = 1'b1;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign count    = count_q;
    assign overflow = ovf_q;
    assign busy     = busy_w;

endmodule
